// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with valid/ready handshakes and a one-bit-per-clock shifter
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam logic [3:0] OP_OR    = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_NOR   = 4'd3;
  localparam logic [3:0] OP_NOT_A = 4'd4;
  localparam logic [3:0] OP_PASSA = 4'd5;
  localparam logic [3:0] OP_PASSB = 4'd6;
  localparam logic [3:0] OP_ADD   = 4'd7;
  localparam logic [3:0] OP_SUB   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_SLL   = 4'd11;
  localparam logic [3:0] OP_SRL   = 4'd12;
  localparam logic [3:0] OP_SRA   = 4'd13;

  // Shift kind is the low two opcode bits: SLL=11, SRL=00, SRA=01
  localparam logic [1:0] K_SLL = 2'b11;
  localparam logic [1:0] K_SRL = 2'b00;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic [1:0]       kind;

  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic             accept;
  logic             load;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic [WIDTH-1:0] step_w;
  logic             step_c;
  logic [WIDTH-1:0] ld_res;
  logic             ld_c;
  logic             ld_v;
  logic             ld_err;

  assign amt      = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_OR:    alu_res = a | b;
      OP_AND:   alu_res = a & b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOR:   alu_res = ~(a | b);
      OP_NOT_A: alu_res = ~a;
      OP_PASSA: alu_res = a;
      OP_PASSB: alu_res = b;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      // Only zero-amount shifts complete here; the rest go through SHIFT
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    step_w = work;
    step_c = 1'b0;
    case (kind)
      K_SLL: begin
        step_w = {work[WIDTH-2:0], 1'b0};
        step_c = work[WIDTH-1];
      end
      K_SRL: begin
        step_w = {1'b0, work[WIDTH-1:1]};
        step_c = work[0];
      end
      default: begin
        step_w = {work[WIDTH-1], work[WIDTH-1:1]};
        step_c = work[0];
      end
    endcase
  end

  assign ld_res = (state == SHIFT) ? step_w : alu_res;
  assign ld_c   = (state == SHIFT) ? step_c : alu_c;
  assign ld_v   = (state == SHIFT) ? 1'b0   : alu_v;
  assign ld_err = (state == SHIFT) ? 1'b0   : alu_err;
  assign load   = ((state == IDLE) && accept && !(is_shift && (amt != '0))) ||
                  ((state == SHIFT) && (cnt == SHW'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      kind      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (load) begin
        result    <= ld_res;
        flag_z    <= (ld_res == '0);
        flag_n    <= ld_res[WIDTH-1];
        flag_c    <= ld_c;
        flag_v    <= ld_v;
        err       <= ld_err;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept && is_shift && (amt != '0)) begin
            work  <= a;
            cnt   <= amt;
            kind  <= op[1:0];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= step_w;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) state <= IDLE;
        end
      endcase
    end
  end

endmodule
